// File: rtl/p1_sprite_render_if.sv
`default_nettype none
// ============================================================================
// Module   : p1_sprite_render_if
// Brief    : Scan-position, sprite-ROM and red-pixel signals of the P1 sprite stage.
// Revision : 1.0
// ============================================================================
interface p1_sprite_render_if;
  logic [9:0]  pix_x;
  logic [9:0]  pix_y;
  logic        de;
  logic [9:0]  rom_addr;
  logic [15:0] bitmap;
  logic        red_on;

  modport master (
    output pix_x, pix_y, de, bitmap,
    input  rom_addr, red_on
  );

  modport slave (
    input  pix_x, pix_y, de, bitmap,
    output rom_addr, red_on
  );
endinterface
`default_nettype wire

// File: rtl/p1_sprite_render.sv
`default_nettype none
// ============================================================================
// Module   : p1_sprite_render
// Brief    : Player-1 animation sequencer and 3-stage red-pixel lookup pipeline.
// Revision : 1.0
// ============================================================================
module p1_sprite_render #(
  parameter int SCALE_LOG2     = 2,
  parameter int TICKS_PER_STEP = 6
) (
  input  wire logic          clk,
  input  wire logic          rst,
  p1_sprite_render_if.slave  bus,
  input  wire logic [9:0]    i_pos_x,
  input  wire logic [9:0]    i_pos_y,
  input  wire logic          i_flip,
  input  wire logic [2:0]    i_act_req,
  input  wire logic          i_frame_tick,
  output logic      [2:0]    o_cur_act,
  output logic      [1:0]    o_cur_frame,
  output logic               o_act_done
);

  localparam logic [10:0] C_BOX      = 11'(16 << SCALE_LOG2);
  localparam logic [7:0]  C_CTR_LAST = 8'(TICKS_PER_STEP - 1);

  typedef enum logic [0:0] {
    S_IDLE_LOOP = 1'b0,
    S_ONE_SHOT  = 1'b1
  } state_t;

  state_t     r_state, w_state_nxt;
  logic [2:0] r_act,   w_act_nxt;
  logic [1:0] r_frame, w_frame_nxt;
  logic [7:0] r_ctr,   w_ctr_nxt;
  logic       r_done,  w_done_nxt;
  logic [2:0] w_req;

  assign w_req = (i_act_req > 3'd4) ? 3'd0 : i_act_req;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE_LOOP;
      r_act   <= 3'd0;
      r_frame <= 2'd0;
      r_ctr   <= 8'd0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_act   <= w_act_nxt;
      r_frame <= w_frame_nxt;
      r_ctr   <= w_ctr_nxt;
      r_done  <= w_done_nxt;
    end
  end

  // Everything holds between frame ticks so a video frame never tears.
  always_comb begin
    w_state_nxt = r_state;
    w_act_nxt   = r_act;
    w_frame_nxt = r_frame;
    w_ctr_nxt   = r_ctr;
    w_done_nxt  = 1'b0;
    if (i_frame_tick) begin
      case (r_state)
        S_IDLE_LOOP: begin
          if (w_req != r_act) begin
            w_act_nxt   = w_req;
            w_frame_nxt = 2'd0;
            w_ctr_nxt   = 8'd0;
            if (w_req == 3'd3 || w_req == 3'd4) w_state_nxt = S_ONE_SHOT;
          end else if (r_ctr == C_CTR_LAST) begin
            w_ctr_nxt   = 8'd0;
            w_frame_nxt = r_frame + 2'd1;
          end else begin
            w_ctr_nxt   = r_ctr + 8'd1;
          end
        end
        S_ONE_SHOT: begin
          if (r_ctr == C_CTR_LAST) begin
            w_ctr_nxt = 8'd0;
            if (r_frame == 2'd3) begin
              w_act_nxt   = 3'd0;
              w_frame_nxt = 2'd0;
              w_done_nxt  = 1'b1;
              w_state_nxt = S_IDLE_LOOP;
            end else begin
              w_frame_nxt = r_frame + 2'd1;
            end
          end else begin
            w_ctr_nxt = r_ctr + 8'd1;
          end
        end
        default: w_state_nxt = S_IDLE_LOOP;
      endcase
    end
  end

  assign o_cur_act   = r_act;
  assign o_cur_frame = r_frame;
  assign o_act_done  = r_done;

  logic [9:0] w_dx, w_dy;
  logic       w_in_box;
  logic [3:0] w_row, w_col_raw, w_col;

  assign w_dx = bus.pix_x - i_pos_x;
  assign w_dy = bus.pix_y - i_pos_y;

  // The >= terms reject scan positions left/above the box that would wrap dx/dy.
  assign w_in_box = bus.de
                  && (bus.pix_x >= i_pos_x) && ({1'b0, w_dx} < C_BOX)
                  && (bus.pix_y >= i_pos_y) && ({1'b0, w_dy} < C_BOX);

  assign w_row     = w_in_box ? 4'(w_dy >> SCALE_LOG2) : 4'd0;
  assign w_col_raw = 4'(w_dx >> SCALE_LOG2);
  assign w_col     = i_flip ? (4'd15 - w_col_raw) : w_col_raw;

  logic [9:0] r_rom_addr;
  logic       r_v1, r_v2, r_red_on;
  logic [3:0] r_c1, r_c2;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rom_addr <= 10'd0;
      r_v1       <= 1'b0;
      r_c1       <= 4'd0;
      r_v2       <= 1'b0;
      r_c2       <= 4'd0;
      r_red_on   <= 1'b0;
    end else begin
      r_rom_addr <= {w_row, r_act, 1'b0, r_frame};
      r_v1       <= w_in_box;
      r_c1       <= w_col;
      r_v2       <= r_v1;
      r_c2       <= r_c1;
      // Bitmap bit 15 is the leftmost column; a cleared bit is an opaque red pixel.
      r_red_on   <= r_v2 & ~bus.bitmap[4'd15 - r_c2];
    end
  end

  assign bus.rom_addr = r_rom_addr;
  assign bus.red_on   = r_red_on;

endmodule
`default_nettype wire
